// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan sequencer.
// Holds the FSM state enum, vector/counter widths and a saturating adder.
package demorgan_pkg;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 4;
  localparam int VEC_W       = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } seqState_t;

  typedef logic [ERR_W-1:0] errCount_t;
  typedef logic [VEC_W-1:0] vec_t;

  // Adds 0..2 mismatches, clamping at the counter maximum.
  function automatic errCount_t satAdd(
    input errCount_t base,
    input logic [1:0] inc
  );
    logic [ERR_W:0] sum;
    sum = {1'b0, base}
        + {{(ERR_W-1){1'b0}}, inc};
    if (sum[ERR_W]) return '1;
    return sum[ERR_W-1:0];
  endfunction

endpackage

// File: rtl/demorgan_gate_unit.sv
// Combinational gate unit: inverters, AND/OR and their De Morgan forms.
// Ports: A, B in; nA, nB, nAandnB, AandB, nAandB, nAornB, AorB, nAorB out.
module demorgan_gate_unit (
  input  logic A,
  input  logic B,
  output logic nA,
  output logic nB,
  output logic nAandnB,
  output logic AandB,
  output logic nAandB,
  output logic nAornB,
  output logic AorB,
  output logic nAorB
);

  assign nA      = ~A;
  assign nB      = ~B;
  assign nAandnB = nA & nB;
  assign AandB   = A & B;
  // nAandB is NAND, nAorB is NOR
  assign nAandB  = ~AandB;
  assign nAornB  = nA | nB;
  assign AorB    = A | B;
  assign nAorB   = ~AorB;

endmodule

// File: rtl/demorgan_sequencer.sv
// Sweeps {A,B} through 00..11 and checks both De Morgan identities.
// Ports: clk, reset, start, abort, [fault_inj if DEMORGAN_FAULT_INJECT_EN];
// out: a_drv, b_drv, busy, done, pass, err_count, first_fail_vec/_valid.
module demorgan_sequencer
  import demorgan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
`ifdef DEMORGAN_FAULT_INJECT_EN
  input  logic            fault_inj,
`endif
  output logic            a_drv,
  output logic            b_drv,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
  localparam vec_t LAST_VEC = VEC_W'(NUM_VECTORS - 1);

  seqState_t state, stateNext;
  vec_t      vecIdx, vecIdxNext;
  vec_t      drv, drvNext;
  logic [3:0] settleCnt, settleCntNext;
  logic      busyNext, doneNext, passNext;
  errCount_t errNext;
  vec_t      ffVecNext;
  logic      ffValidNext;

  logic nAandnB, nAornB, nAandB, nAorB;
  logic unusedNa, unusedNb;
  logic unusedAandB, unusedAorB;
  logic cmpAndnB;
  logic misNor, misNand;
  logic [1:0] misCnt;
  logic inSweep;

  assign a_drv = drv[1];
  assign b_drv = drv[0];

  demorgan_gate_unit uGate (
    .A       (drv[1]),
    .B       (drv[0]),
    .nA      (unusedNa),
    .nB      (unusedNb),
    .nAandnB (nAandnB),
    .AandB   (unusedAandB),
    .nAandB  (nAandB),
    .nAornB  (nAornB),
    .AorB    (unusedAorB),
    .nAorB   (nAorB)
  );

`ifdef DEMORGAN_FAULT_INJECT_EN
  assign cmpAndnB = nAandnB ^ fault_inj;
`else
  assign cmpAndnB = nAandnB;
`endif

  assign misNor  = cmpAndnB != nAorB;
  assign misNand = nAornB != nAandB;
  assign misCnt  = {misNor & misNand,
                    misNor ^ misNand};

  assign inSweep = (state == APPLY)
                || (state == SETTLE)
                || (state == CHECK);

  always_comb begin
    stateNext     = state;
    vecIdxNext    = vecIdx;
    drvNext       = drv;
    settleCntNext = settleCnt;
    doneNext      = 1'b0;
    passNext      = pass;
    errNext       = err_count;
    ffVecNext     = first_fail_vec;
    ffValidNext   = first_fail_valid;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext   = APPLY;
          vecIdxNext  = '0;
          errNext     = '0;
          ffValidNext = 1'b0;
          passNext    = 1'b0;
        end
      end
      APPLY: begin
        drvNext       = vecIdx;
        settleCntNext = '0;
        stateNext     = (SETTLE_CYCLES == 0)
                      ? CHECK : SETTLE;
      end
      SETTLE: begin
        settleCntNext = settleCnt + 4'd1;
        if (settleCnt == SETTLE_LAST)
          stateNext = CHECK;
      end
      CHECK: begin
        errNext = satAdd(err_count, misCnt);
        if (misCnt != 2'd0 && !first_fail_valid) begin
          ffVecNext   = drv;
          ffValidNext = 1'b1;
        end
        if (vecIdx == LAST_VEC) begin
          stateNext = DONE;
        end else begin
          stateNext  = APPLY;
          vecIdxNext = vecIdx + 1'b1;
        end
      end
      DONE: begin
        doneNext  = 1'b1;
        passNext  = (err_count == '0);
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    // Abort wins over every in-sweep update, including a CHECK tally.
    if (abort && inSweep) begin
      stateNext     = IDLE;
      vecIdxNext    = vecIdx;
      drvNext       = drv;
      settleCntNext = settleCnt;
      errNext       = err_count;
      ffVecNext     = first_fail_vec;
      ffValidNext   = first_fail_valid;
    end
    busyNext = (stateNext == APPLY)
            || (stateNext == SETTLE)
            || (stateNext == CHECK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      vecIdx           <= '0;
      drv              <= '0;
      settleCnt        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= stateNext;
      vecIdx           <= vecIdxNext;
      drv              <= drvNext;
      settleCnt        <= settleCntNext;
      busy             <= busyNext;
      done             <= doneNext;
      pass             <= passNext;
      err_count        <= errNext;
      first_fail_vec   <= ffVecNext;
      first_fail_valid <= ffValidNext;
    end
  end

endmodule

// File: tb/tb_demorgan_sequencer.sv
// Directed bench for demorgan_sequencer (SETTLE_CYCLES=1 and =0).
// Cycle c is the interval after the c-th edge following the start edge.
module tb_demorgan_sequencer;

  logic clk = 1'b0;
  logic reset, start, abort;
`ifdef DEMORGAN_FAULT_INJECT_EN
  logic faultInj;
`endif

  logic a1, b1, busy1, done1, pass1, ffValid1;
  logic [3:0] err1;
  logic [1:0] ffVec1;
  logic a0, b0, busy0, done0, pass0, ffValid0;
  logic [3:0] err0;
  logic [1:0] ffVec0;

  int checks = 0;
  int failures = 0;

  int expVec1 [14] = '{0,0,0,0,1,1,1,2,2,2,3,3,3,3};
  int expVec0 [10] = '{0,0,0,1,1,2,2,3,3,3};

  always #5 clk = ~clk;

  demorgan_sequencer #(.SETTLE_CYCLES(1)) uDut1 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
`ifdef DEMORGAN_FAULT_INJECT_EN
    .fault_inj        (faultInj),
`endif
    .a_drv            (a1),
    .b_drv            (b1),
    .busy             (busy1),
    .done             (done1),
    .pass             (pass1),
    .err_count        (err1),
    .first_fail_vec   (ffVec1),
    .first_fail_valid (ffValid1)
  );

  demorgan_sequencer #(.SETTLE_CYCLES(0)) uDut0 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
`ifdef DEMORGAN_FAULT_INJECT_EN
    .fault_inj        (faultInj),
`endif
    .a_drv            (a0),
    .b_drv            (b0),
    .busy             (busy0),
    .done             (done0),
    .pass             (pass0),
    .err_count        (err0),
    .first_fail_vec   (ffVec0),
    .first_fail_valid (ffValid0)
  );

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({a1,b1,busy1,done1,pass1,err1,ffVec1,ffValid1}
        !== 12'd0) begin
      failures++;
      $display("FAIL reset1 got=%b exp=0",
        {a1,b1,busy1,done1,pass1,err1,ffVec1,ffValid1});
    end
    checks++;
    if ({a0,b0,busy0,done0,pass0,err0,ffVec0,ffValid0}
        !== 12'd0) begin
      failures++;
      $display("FAIL reset0 got=%b exp=0",
        {a0,b0,busy0,done0,pass0,err0,ffVec0,ffValid0});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b exp=0", busy1);
    end
  endtask

  task automatic test_sweep(input bit repulse);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) @(negedge clk);
      if (repulse) start = (c == 3 || c == 7);
      if (c >= 1 && c <= 13) begin
        checks++;
        if ({a1,b1} !== 2'(expVec1[c])) begin
          failures++;
          $display("FAIL sweep_vec c=%0d got=%b exp=%0d",
            c, {a1,b1}, expVec1[c]);
        end
      end
      checks++;
      if (busy1 !== (c <= 11)) begin
        failures++;
        $display("FAIL sweep_busy c=%0d got=%b exp=%b",
          c, busy1, (c <= 11));
      end
      checks++;
      if (done1 !== (c == 13)) begin
        failures++;
        $display("FAIL sweep_done c=%0d got=%b exp=%b",
          c, done1, (c == 13));
      end
      if (c == 13) begin
        checks++;
        if ({pass1,err1,ffValid1} !== 6'b1_0000_0) begin
          failures++;
          $display("FAIL sweep_result pass=%b err=%0d ffv=%b exp=1,0,0",
            pass1, err1, ffValid1);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    test_sweep(1'b1);
  endtask

  task automatic test_abort();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) @(negedge clk);
      abort = (c == 5);
      if (c >= 6) begin
        checks++;
        if (busy1 !== 1'b0) begin
          failures++;
          $display("FAIL abort_busy c=%0d got=%b exp=0", c, busy1);
        end
      end
      checks++;
      if (done1 !== 1'b0) begin
        failures++;
        $display("FAIL abort_done c=%0d got=%b exp=0", c, done1);
      end
    end
    abort = 1'b0;
    checks++;
    if (pass1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_pass got=%b exp=0", pass1);
    end
    test_sweep(1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy1 !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy_before got=%b exp=1", busy1);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a1,b1,busy1,done1,pass1,err1,ffVec1,ffValid1}
        !== 12'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b exp=0",
        {a1,b1,busy1,done1,pass1,err1,ffVec1,ffValid1});
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy1,done1,a1,b1} !== 4'd0) begin
      failures++;
      $display("FAIL mid_idle got=%b exp=0000",
        {busy1,done1,a1,b1});
    end
    test_sweep(1'b0);
  endtask

  task automatic test_settle0();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= 9) begin
        checks++;
        if ({a0,b0} !== 2'(expVec0[c])) begin
          failures++;
          $display("FAIL s0_vec c=%0d got=%b exp=%0d",
            c, {a0,b0}, expVec0[c]);
        end
      end
      checks++;
      if (done0 !== (c == 9)) begin
        failures++;
        $display("FAIL s0_done c=%0d got=%b exp=%b",
          c, done0, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if ({pass0,err0} !== 5'b1_0000) begin
          failures++;
          $display("FAIL s0_result pass=%b err=%0d exp=1,0",
            pass0, err0);
        end
      end
    end
    repeat (8) @(negedge clk);
  endtask

`ifdef DEMORGAN_FAULT_INJECT_EN
  task automatic test_fault_inject();
    faultInj = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    checks++;
    if (done1 !== 1'b1) begin
      failures++;
      $display("FAIL fi_done got=%b exp=1", done1);
    end
    checks++;
    if ({pass1,err1,ffVec1,ffValid1} !== 8'b0_0100_00_1) begin
      failures++;
      $display("FAIL fi_result pass=%b err=%0d ffv=%b ffvld=%b exp=0,4,00,1",
        pass1, err1, ffVec1, ffValid1);
    end
    faultInj = 1'b0;
    repeat (4) @(negedge clk);
  endtask
`endif

  initial begin
`ifdef DEMORGAN_FAULT_INJECT_EN
    faultInj = 1'b0;
`endif
    test_reset();
    test_sweep(1'b0);
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_settle0();
`ifdef DEMORGAN_FAULT_INJECT_EN
    test_fault_inject();
`endif
    $display("TB_RESULT checks=%0d failures=%0d",
      checks, failures);
    $finish;
  end

endmodule
